// File: rtl/ex_mem_agu_if.sv
// Request/address-ok data bus between the execute-stage memory unit (master) and the memory system (slave).
interface ex_mem_agu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_wstrb,
        output data_addr,
        output data_wdata,
        input  data_addr_ok
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_wstrb,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok
    );
endinterface

// File: rtl/ex_mem_agu.sv
// Execute-stage memory access unit: strobes, lane-replicated store data, alignment check, bus issue, MEM hand-off.
// Define MEM_ALE_CHECK_EN to raise alignment exceptions; otherwise addresses are forced to size alignment.
module ex_mem_agu #(
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    ex_mem_agu_if.master      bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ale,
    output logic              out_mem_issued,
    output logic [OFF_W-1:0]  out_byte_off
);
    typedef logic [LANES-1:0] strb_t;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic strb_t calc_strb(input logic [1:0] size, input logic [OFF_W-1:0] off);
        strb_t base;
        base = '0;
        case (size)
            2'd0:    base = strb_t'(1'b1);
            2'd1:    base = strb_t'(2'b11);
            2'd2:    base = strb_t'(4'hF);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    // A double on a 32-bit path is a full word, so the default arm covers both widths.
    function automatic logic [DATA_W-1:0] calc_wdata(input logic [1:0] size, input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] r;
        r = '0;
        case (size)
            2'd0:    r = {(DATA_W/8){data[7:0]}};
            2'd1:    r = {(DATA_W/16){data[15:0]}};
            2'd2:    r = {(DATA_W/32){data[31:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic calc_ale(input logic [1:0] size, input logic [2:0] addr_lo);
        logic r;
        r = 1'b0;
        case (size)
            2'd0:    r = 1'b0;
            2'd1:    r = addr_lo[0];
            2'd2:    r = |addr_lo[1:0];
            default: r = (DATA_W == 64) ? (|addr_lo[2:0]) : (|addr_lo[1:0]);
        endcase
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] calc_align(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] m;
        m = '1;
        case (size)
            2'd0:    m = '1;
            2'd1:    m[0] = 1'b0;
            2'd2:    m[1:0] = 2'b00;
            default: begin
                if (DATA_W == 64) begin
                    m[2:0] = 3'b000;
                end else begin
                    m[1:0] = 2'b00;
                end
            end
        endcase
        return addr & m;
    endfunction

    state_t            state_q, state_d;
    logic              is_mem_s, ale_s, accept_s;
    state_t            accept_state_s;
    logic [ADDR_W-1:0] eff_addr_s;
    logic              flush_pend_q, flush_pend_d;
    logic              req_q, valid_q, wr_q, ale_q, issued_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    strb_t             strb_q;
    logic [DATA_W-1:0] wdata_q;

    assign is_mem_s = in_load | in_store;

`ifdef MEM_ALE_CHECK_EN
    assign ale_s      = is_mem_s & calc_ale(in_size, in_addr[2:0]);
    assign eff_addr_s = in_addr;
`else
    assign ale_s      = 1'b0;
    assign eff_addr_s = calc_align(in_size, in_addr);
`endif

    assign accept_state_s = (is_mem_s && !ale_s) ? REQ : HOLD;

    // Next-state, accept and in_ready decode.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        accept_s     = 1'b0;
        flush_pend_d = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept_s = 1'b1;
                    state_d  = accept_state_s;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // A request already on the bus must complete; a flush only diverts it to DRAIN.
                if (bus.data_addr_ok) begin
                    flush_pend_d = 1'b0;
                    state_d      = (flush_pend_q || flush) ? DRAIN : HOLD;
                end else begin
                    flush_pend_d = flush_pend_q | flush;
                    state_d      = REQ;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept_s = 1'b1;
                        state_d  = accept_state_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered bus/valid control outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            issued_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            req_q        <= (state_d == REQ);
            valid_q      <= (state_d == HOLD);
            if (accept_s) begin
                issued_q <= 1'b0;
            end else if ((state_q == REQ) && bus.data_addr_ok) begin
                issued_q <= 1'b1;
            end
        end
    end

    // Operation fields captured at accept; they stay stable through REQ and HOLD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            ale_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else if (accept_s) begin
            wr_q    <= in_store;
            size_q  <= in_size;
            addr_q  <= eff_addr_s;
            ale_q   <= ale_s;
            strb_q  <= (in_store && !ale_s) ? calc_strb(in_size, eff_addr_s[OFF_W-1:0]) : '0;
            wdata_q <= in_store ? calc_wdata(in_size, in_wdata) : '0;
        end
    end

    assign bus.data_req    = req_q;
    assign bus.data_wr     = wr_q;
    assign bus.data_size   = size_q;
    assign bus.data_wstrb  = strb_q;
    assign bus.data_addr   = addr_q;
    assign bus.data_wdata  = wdata_q;
    assign out_valid       = valid_q;
    assign out_ale         = ale_q;
    assign out_mem_issued  = issued_q;
    assign out_byte_off    = addr_q[OFF_W-1:0];
endmodule

// File: tb/tb_ex_mem_agu.sv
// Bench for ex_mem_agu: a 32-bit and a 64-bit instance driven with identical directed operations.
module tb_ex_mem_agu;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        in_valid, in_load, in_store, flush, out_ready, addr_ok;
    logic [1:0]  in_size;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic        rdy32, rdy64, ov32, ov64, ale32, ale64, iss32, iss64;
    logic [1:0]  off32;
    logic [2:0]  off64;

    ex_mem_agu_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    ex_mem_agu_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();
    assign bus32.data_addr_ok = addr_ok;
    assign bus64.data_addr_ok = addr_ok;

    ex_mem_agu #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy32),
        .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_addr(in_addr),
        .in_wdata(in_wdata[31:0]), .flush(flush), .bus(bus32), .out_valid(ov32),
        .out_ready(out_ready), .out_ale(ale32), .out_mem_issued(iss32), .out_byte_off(off32)
    );
    ex_mem_agu #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy64),
        .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_addr(in_addr),
        .in_wdata(in_wdata), .flush(flush), .bus(bus64), .out_valid(ov64),
        .out_ready(out_ready), .out_ale(ale64), .out_mem_issued(iss64), .out_byte_off(off64)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int ov_log[$];

    // Reference: the operation most recently accepted
    bit          m_live = 1'b0;
    logic        m_load, m_store;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [63:0] m_wd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input int w, input logic [1:0] s);
        return (s == 2'd3) ? (w / 8) : (1 << s);
    endfunction

    function automatic bit f_ale(input int w, input logic [1:0] s, input logic [31:0] a, input bit mem);
`ifdef MEM_ALE_CHECK_EN
        return mem && ((a % 32'(nbytes(w, s))) != 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] f_addr(input int w, input logic [1:0] s, input logic [31:0] a);
`ifdef MEM_ALE_CHECK_EN
        return a;
`else
        return a - (a % 32'(nbytes(w, s)));
`endif
    endfunction

    function automatic logic [63:0] f_strb(input int w, input logic [1:0] s, input logic [31:0] a,
                                           input bit st, input bit mem);
        logic [63:0] r;
        int off;
        r = '0;
        if (!st || f_ale(w, s, a, mem)) return r;
        off = int'(f_addr(w, s, a) % 32'(w / 8));
        for (int i = 0; i < nbytes(w, s); i++) r[off + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] f_wdata(input int w, input logic [1:0] s, input logic [63:0] d, input bit st);
        logic [63:0] r;
        int n;
        r = '0;
        if (!st) return r;
        n = nbytes(w, s);
        for (int i = 0; i < w / 8; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic cmp_one(input string t, input int w, input logic req, input logic [31:0] addr,
                           input logic wr, input logic [1:0] sz, input logic [63:0] strb,
                           input logic [63:0] wd, input logic ov, input logic ale, input logic iss,
                           input logic [2:0] off, input logic rdy);
        bit mem;
        bit eale;
        mem  = m_load | m_store;
        eale = f_ale(w, m_size, m_addr, mem);
        if (req) begin
            chk({t, " data_addr"},  64'(addr), 64'(f_addr(w, m_size, m_addr)));
            chk({t, " data_wr"},    64'(wr),   64'(m_store));
            chk({t, " data_size"},  64'(sz),   64'(m_size));
            chk({t, " data_wstrb"}, strb,      f_strb(w, m_size, m_addr, m_store, mem));
            chk({t, " data_wdata"}, wd,        f_wdata(w, m_size, m_wd, m_store));
            chk({t, " in_ready_in_req"},  64'(rdy), 64'd0);
            chk({t, " valid_during_req"}, 64'(ov),  64'd0);
        end
        if (ov) begin
            chk({t, " out_ale"},        64'(ale), 64'(eale));
            chk({t, " out_mem_issued"}, 64'(iss), 64'(mem && !eale));
            chk({t, " out_byte_off"},   64'(off), 64'(f_addr(w, m_size, m_addr) % 32'(w / 8)));
        end
    endtask

    // Per-cycle comparison of both instances against the reference
    always @(negedge clk) begin
        if (resetn && m_live) begin
            cmp_one("d32", 32, bus32.data_req, bus32.data_addr, bus32.data_wr, bus32.data_size,
                    64'(bus32.data_wstrb), 64'(bus32.data_wdata), ov32, ale32, iss32, {1'b0, off32}, rdy32);
            cmp_one("d64", 64, bus64.data_req, bus64.data_addr, bus64.data_wr, bus64.data_size,
                    64'(bus64.data_wstrb), bus64.data_wdata, ov64, ale64, iss64, off64, rdy64);
        end
        if (ov64) ov_log.push_back(cyc);
    end

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic [31:0] a,
                         input logic [63:0] d);
        int n;
        n = 0;
        in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_addr = a; in_wdata = d;
        @(negedge clk);
        while (!rdy64 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_in_ready", 64'(rdy64), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_live = 1'b1; m_load = ld; m_store = st; m_size = sz; m_addr = a; m_wd = d;
        last_acc = cyc;
    endtask

    // Called at cycle t+1 after accept; addr_ok arrives in cycle t+k.
    task automatic finish_mem(input int k);
        for (int i = 1; i <= k; i++) begin
            if (i == k) addr_ok = 1'b1;
            @(negedge clk);
            chk("req_wait data_req", 64'(bus64.data_req), 64'd1);
            chk("req_wait out_valid", 64'(ov64), 64'd0);
            @(posedge clk); #1;
        end
        addr_ok = 1'b0;
        @(negedge clk);
        chk("mem out_valid", 64'(ov64), 64'd1);
        chk("mem out_valid32", 64'(ov32), 64'd1);
        chk("mem data_req_drop", 64'(bus64.data_req), 64'd0);
        chk("mem out_mem_issued", 64'(iss64), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'd0; in_addr = 32'd0;
        in_wdata = 64'd0; flush = 1'b0; out_ready = 1'b1; addr_ok = 1'b0; resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst data_req64", 64'(bus64.data_req), 64'd0);
        chk("rst out_valid64", 64'(ov64), 64'd0);
        chk("rst out_ale64", 64'(ale64), 64'd0);
        chk("rst wstrb64", 64'(bus64.data_wstrb), 64'd0);
        chk("rst wdata64", bus64.data_wdata, 64'd0);
        chk("rst addr64", 64'(bus64.data_addr), 64'd0);
        chk("rst issued64", 64'(iss64), 64'd0);
        chk("rst data_req32", 64'(bus32.data_req), 64'd0);
        chk("rst wdata32", 64'(bus32.data_wdata), 64'd0);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("post_rst in_ready64", 64'(rdy64), 64'd1);
        chk("post_rst in_ready32", 64'(rdy32), 64'd1);
        @(posedge clk); #1;

        // Store byte at 0x1003, addr_ok two cycles later
        issue(1'b0, 1'b1, 2'd0, 32'h1003, 64'h0000_00A5);
        chk("sb data_req", 64'(bus32.data_req), 64'd1);
        chk("sb wstrb32", 64'(bus32.data_wstrb), 64'h8);
        chk("sb wdata32", 64'(bus32.data_wdata), 64'hA5A5_A5A5);
        chk("sb wstrb64", 64'(bus64.data_wstrb), 64'h08);
        chk("sb wdata64", bus64.data_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
        finish_mem(2);
        chk("sb latency", 64'(ov_log[$] - last_acc), 64'd2);

        // Store half at 0x2006, addr_ok in the first REQ cycle
        issue(1'b0, 1'b1, 2'd1, 32'h2006, 64'h1234);
        chk("sh wstrb64", 64'(bus64.data_wstrb), 64'hC0);
        chk("sh wdata64", bus64.data_wdata, 64'h1234_1234_1234_1234);
        chk("sh wstrb32", 64'(bus32.data_wstrb), 64'hC);
        chk("sh wdata32", 64'(bus32.data_wdata), 64'h1234_1234);
        finish_mem(1);

        // Load double at 0x2000
        issue(1'b1, 1'b0, 2'd3, 32'h2000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ld wstrb64", 64'(bus64.data_wstrb), 64'd0);
        chk("ld data_wr64", 64'(bus64.data_wr), 64'd0);
        chk("ld addr64", 64'(bus64.data_addr), 64'h2000);
        chk("ld wstrb32", 64'(bus32.data_wstrb), 64'd0);
        finish_mem(3);

        issue(1'b0, 1'b1, 2'd2, 32'h2004, 64'hDEAD_BEEF);
        chk("sw wstrb64", 64'(bus64.data_wstrb), 64'hF0);
        chk("sw wdata64", bus64.data_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
        finish_mem(1);
        issue(1'b0, 1'b1, 2'd3, 32'h2008, 64'h0123_4567_89AB_CDEF);
        chk("sd wstrb64", 64'(bus64.data_wstrb), 64'hFF);
        chk("sd wdata32", 64'(bus32.data_wdata), 64'h89AB_CDEF);
        finish_mem(2);

        // Misaligned load word at 0x3002
        issue(1'b1, 1'b0, 2'd2, 32'h3002, 64'd0);
`ifdef MEM_ALE_CHECK_EN
        @(negedge clk);
        chk("ale no data_req", 64'(bus64.data_req), 64'd0);
        chk("ale out_valid", 64'(ov64), 64'd1);
        chk("ale out_ale64", 64'(ale64), 64'd1);
        chk("ale out_ale32", 64'(ale32), 64'd1);
        chk("ale issued", 64'(iss64), 64'd0);
        @(posedge clk); #1;
`else
        chk("align addr64", 64'(bus64.data_addr), 64'h3000);
        chk("align addr32", 64'(bus32.data_addr), 64'h3000);
        addr_ok = 1'b1;
        @(negedge clk);
        chk("align data_req", 64'(bus64.data_req), 64'd1);
        @(posedge clk); #1;
        addr_ok = 1'b0;
        @(negedge clk);
        chk("align out_valid", 64'(ov64), 64'd1);
        chk("align out_ale64", 64'(ale64), 64'd0);
        @(posedge clk); #1;
`endif

        // Flush one cycle into REQ; addr_ok low for three cycles
        issue(1'b1, 1'b0, 2'd2, 32'h4000, 64'd0);
        for (int i = 1; i <= 4; i++) begin
            flush   = (i == 2);
            addr_ok = (i == 4);
            @(negedge clk);
            chk("flush data_req", 64'(bus64.data_req), 64'd1);
            chk("flush in_ready", 64'(rdy64), 64'd0);
            chk("flush out_valid", 64'(ov64), 64'd0);
            @(posedge clk); #1;
        end
        flush = 1'b0; addr_ok = 1'b0;
        @(negedge clk);
        chk("drain data_req", 64'(bus64.data_req), 64'd0);
        chk("drain out_valid", 64'(ov64), 64'd0);
        chk("drain in_ready", 64'(rdy64), 64'd0);
        chk("drain in_ready32", 64'(rdy32), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_drain in_ready", 64'(rdy64), 64'd1);
        chk("after_drain out_valid", 64'(ov64), 64'd0);
        @(posedge clk); #1;

        // Three back-to-back non-memory ops, then two stall cycles
        ov_log.delete();
        issue(1'b0, 1'b0, 2'd0, 32'h11, 64'd0);
        begin
            int first;
            first = last_acc;
            issue(1'b0, 1'b0, 2'd0, 32'h22, 64'd0);
            issue(1'b0, 1'b0, 2'd0, 32'h37, 64'd0);
            out_ready = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("stall in_ready", 64'(rdy64), 64'd0);
                chk("stall out_valid", 64'(ov64), 64'd1);
                chk("stall byte_off64", 64'(off64), 64'd7);
                chk("stall byte_off32", 64'(off32), 64'd3);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("release out_valid", 64'(ov64), 64'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle out_valid", 64'(ov64), 64'd0);
            chk("idle in_ready", 64'(rdy64), 64'd1);
            chk("b2b valid count", 64'(ov_log.size()), 64'd5);
            for (int i = 0; i < ov_log.size(); i++) chk("b2b valid cycle", 64'(ov_log[i]), 64'(first + i));
            @(posedge clk); #1;
        end

        // Asynchronous reset while in REQ
        issue(1'b1, 1'b0, 2'd2, 32'h5000, 64'd0);
        chk("pre_rst data_req", 64'(bus64.data_req), 64'd1);
        #2;
        m_live = 1'b0;
        resetn = 1'b0;
        #1;
        chk("async_rst data_req64", 64'(bus64.data_req), 64'd0);
        chk("async_rst data_req32", 64'(bus32.data_req), 64'd0);
        chk("async_rst out_valid", 64'(ov64), 64'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("rst_rel in_ready", 64'(rdy64), 64'd1);
        chk("rst_rel data_req", 64'(bus64.data_req), 64'd0);
        chk("rst_rel out_valid", 64'(ov64), 64'd0);
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 2'd0, 32'h6001, 64'h5A);
        chk("post_rst wstrb64", 64'(bus64.data_wstrb), 64'h02);
        finish_mem(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ex_mem_agu.md
# ex_mem_agu

Parametrised memory-access unit for the execute stage of the pipelined CPU. It takes a resolved load/store from the ALU, builds byte strobes and lane-replicated write data for 32- or 64-bit data paths, and checks address alignment. It issues the request on a request/address-ok data bus and holds the result until the MEM stage accepts it. It supersedes the fixed 32-bit, single-cycle, always-enabled store logic in the execute stage.

## Interface
- DATA_W, 32, data bus width; legal values 32 or 64
- ADDR_W, 32, address width
- clk  in  1  clock; all state updates on its rising edge
- resetn  in  1  reset; asynchronous, active-low
- in_valid  in  1  execute-stage operation valid (ALU result final)
- in_ready  out  1  block can accept an operation this cycle
- in_load  in  1  operation is a load
- in_store  in  1  operation is a store (in_load and in_store never both 1)
- in_size  in  2  0 byte, 1 half, 2 word, 3 double
- in_addr  in  ADDR_W  effective address (ALU result)
- in_wdata  in  DATA_W  store source register value
- flush  in  1  pipeline cancel (exception/ertn)
- data_req  out  1  bus request
- data_wr  out  1  1 store, 0 load
- data_size  out  2  copy of the registered size
- data_wstrb  out  DATA_W/8  byte write strobes; all 0 for loads
- data_addr  out  ADDR_W  bus address
- data_wdata  out  DATA_W  lane-replicated store data
- data_addr_ok  in  1  bus accepted the request this cycle
- out_valid  out  1  result valid to MEM stage
- out_ready  in  1  MEM stage accepts
- out_ale  out  1  address-alignment exception for this operation
- out_mem_issued  out  1  a bus request was accepted; MEM must wait for data
- out_byte_off  out  log2(DATA_W/8)  low address bits for load extraction

## Operation
- FSM states: IDLE, REQ, HOLD, DRAIN.
- in_ready = (IDLE) | (HOLD & out_ready & ~flush).
- Accept on in_valid & in_ready: register the operation fields.
  - Memory operation without ALE goes to REQ.
  - Non-memory operation or ALE goes to HOLD with out_mem_issued=0.
- REQ:
  - data_req=1; address, strobes, data and wr stay stable.
  - On data_addr_ok, go to HOLD with out_mem_issued=1.
- HOLD:
  - out_valid=1.
  - On out_ready, accept a new operation if in_valid (next state per the accept rule), else go to IDLE.
- Strobes at byte offset o = addr[log2(DATA_W/8)-1:0]:
  - Byte: lane o.
  - Half: lanes o, o+1.
  - Word: 4 lanes from o.
  - Double: all lanes.
- Write data replication:
  - Byte: replicated to every lane.
  - Half: replicated to every 16-bit slot.
  - Word: replicated to every 32-bit slot.
- With DATA_W=32, size 3 behaves as word.
- ALE conditions: half with addr[0]=1; word with addr[1:0]≠0; double with addr[2:0]≠0 (DATA_W=64 only).
- Flush:
  - In IDLE/HOLD: go to IDLE next cycle; out_valid drops.
  - In REQ: keep data_req asserted until data_addr_ok, then go to DRAIN. A bus request is never withdrawn.
  - DRAIN: one cycle, no out_valid, then IDLE. in_ready=0 in REQ and DRAIN.
- Reset: state IDLE; all outputs 0, including data_req, out_valid, out_ale, data_wstrb and data_wdata.

## Timing
- Operation accepted in cycle t.
- Memory op: data_req high from t+1.
  - addr_ok at t+k gives out_valid at t+k+1.
  - Minimum latency is 2 cycles.
- Non-memory or ALE op: out_valid at t+1.
- Back-to-back: a HOLD with out_ready and in_valid in the same cycle sustains 1 op/cycle for non-memory ops.
- All bus outputs are registered; there is no combinational path from in_* to data_*.
- addr_ok in the same cycle data_req rises is legal; REQ lasts one cycle.
- Async reset mid-REQ drops data_req immediately; the bus is also reset by resetn.

## Configuration
- Macro: MEM_ALE_CHECK_EN.
- Defined:
  - Alignment check active as above.
  - Misaligned ops raise out_ale, issue no bus request, and go to HOLD.
- Undefined:
  - out_ale is tied 0.
  - Address low bits are forced to the size-aligned value before strobe generation and data_addr.
  - All memory ops issue.

## Test plan
- DATA_W=32, store byte, addr 0x1003, wdata 0x000000A5, addr_ok after 2 cycles -> data_wstrb 4'b1000, data_wdata 0xA5A5A5A5, out_valid 3 cycles after accept, out_mem_issued=1.
- DATA_W=64, store half, addr 0x2006, wdata 0x1234 -> data_wstrb 8'b1100_0000, data_wdata 0x1234123412341234; load double addr 0x2000 -> wstrb 0, data_wr 0.
- With MEM_ALE_CHECK_EN, load word at addr 0x3002 -> no data_req, out_valid next cycle with out_ale=1; without the macro -> data_addr 0x3000, out_ale=0.
- Flush asserted one cycle into REQ with addr_ok held low 3 cycles -> data_req stays high until addr_ok, one DRAIN cycle, no out_valid, in_ready=0 throughout.
- Three non-memory ops back-to-back with out_ready=1 -> out_valid continuous for 3 cycles; then out_ready low 2 cycles -> HOLD kept, in_ready=0, outputs stable.
- resetn asserted low while in REQ -> data_req and out_valid 0 immediately; after release the state is IDLE and in_ready=1.
